// File: rtl/instr_loader_pkg.sv
// rtl/instr_loader_pkg.sv - shared state encodings and default sizing for instr_loader
package instr_loader_pkg;

    localparam int DEFAULT_DEPTH = 16;
    localparam int DEFAULT_FILL  = 4;
    localparam int DEFAULT_AW    = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CRST,
        ST_WAIT,
        ST_RUN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/loader_buf.sv
// rtl/loader_buf.sv - program/expected/check storage, one host write port, one read port per array
module loader_buf
    import instr_loader_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = DEFAULT_AW
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic          wr_sel,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic          wr_chk,
    input  logic [AW-1:0] prog_addr,
    output logic [31:0]   prog_data,
    input  logic [AW-1:0] exp_addr,
    output logic [31:0]   exp_data,
    output logic          exp_chk
);

    // No reset on purpose: contents must survive a loader reset.
    logic [31:0] prog_mem [DEPTH];
    logic [31:0] exp_mem  [DEPTH];
    logic        chk_mem  [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (!wr_sel) begin
                prog_mem[wr_addr] <= wr_data;
            end else begin
                exp_mem[wr_addr] <= wr_data;
                chk_mem[wr_addr] <= wr_chk;
            end
        end
    end

    assign prog_data = prog_mem[prog_addr];
    assign exp_data  = exp_mem[exp_addr];
    assign exp_chk   = chk_mem[exp_addr];

endmodule

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - loads a program into a CPU, resets it, then checks its result stream
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int FILL  = DEFAULT_FILL,
    parameter int AW    = DEFAULT_AW
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic          wr_en,
    input  logic          wr_sel,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic          wr_chk,
    input  logic          start,
    input  logic [AW:0]   len,
    input  logic [31:0]   cpu_out,
    output logic          cpu_load,
    output logic [31:0]   cpu_instr,
    output logic          cpu_reset,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic          fail,
    output logic [AW-1:0] fail_idx
);

    localparam int CW = (FILL > 1) ? $clog2(FILL) : 1;

    state_t        state, state_nx;
    logic [AW:0]   idx, idx_nx;
    logic [AW:0]   len_q, len_nx;
    logic [CW-1:0] cnt, cnt_nx;

    logic          cpu_load_nx, cpu_reset_nx, busy_nx, done_nx, pass_nx, fail_nx;
    logic [31:0]   cpu_instr_nx;
    logic [AW-1:0] fail_idx_nx;

    logic          idle_like;
    logic [AW:0]   len_sat;
    logic [AW-1:0] prog_addr;
    logic [31:0]   prog_word, exp_word;
    logic          exp_chk;

    assign idle_like = (state == ST_IDLE) || (state == ST_DONE);
    assign len_sat   = (len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : len;
    // Index 0 must already be presented on the start cycle.
    assign prog_addr = idle_like ? '0 : idx[AW-1:0];

    loader_buf #(.DEPTH(DEPTH), .AW(AW)) u_buf (
        .clk       (clk),
        .wr_en     (wr_en && idle_like),
        .wr_sel    (wr_sel),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_chk    (wr_chk),
        .prog_addr (prog_addr),
        .prog_data (prog_word),
        .exp_addr  (idx[AW-1:0]),
        .exp_data  (exp_word),
        .exp_chk   (exp_chk)
    );

    always_comb begin
        state_nx     = state;
        idx_nx       = idx;
        len_nx       = len_q;
        cnt_nx       = cnt;
        cpu_load_nx  = 1'b0;
        cpu_instr_nx = 32'h0;
        cpu_reset_nx = cpu_reset;
        done_nx      = done;
        pass_nx      = pass;
        fail_nx      = fail;
        fail_idx_nx  = fail_idx;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    len_nx      = len_sat;
                    done_nx     = 1'b0;
                    pass_nx     = 1'b0;
                    fail_nx     = 1'b0;
                    fail_idx_nx = '0;
                    idx_nx      = '0;
                    if (len_sat == '0) begin
                        state_nx = ST_DONE;
                        done_nx  = 1'b1;
                        pass_nx  = 1'b1;
                    end else begin
                        state_nx     = ST_LOAD;
                        cpu_load_nx  = 1'b1;
                        cpu_reset_nx = 1'b0;
                        cpu_instr_nx = prog_word;
                        idx_nx       = (AW+1)'(1);
                    end
                end
            end
            ST_LOAD: begin
                if (idx < len_q) begin
                    cpu_load_nx  = 1'b1;
                    cpu_reset_nx = 1'b0;
                    cpu_instr_nx = prog_word;
                    idx_nx       = idx + (AW+1)'(1);
                end else begin
                    state_nx     = ST_CRST;
                    cpu_reset_nx = 1'b1;
                end
            end
            ST_CRST: begin
                state_nx     = ST_WAIT;
                cpu_reset_nx = 1'b0;
                cnt_nx       = '0;
            end
            ST_WAIT: begin
                if (cnt == CW'(FILL - 1)) begin
                    state_nx = ST_RUN;
                    idx_nx   = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            ST_RUN: begin
                if (exp_chk && (cpu_out != exp_word)) begin
                    state_nx    = ST_DONE;
                    done_nx     = 1'b1;
                    fail_nx     = 1'b1;
                    fail_idx_nx = idx[AW-1:0];
                end else if (idx + (AW+1)'(1) == len_q) begin
                    state_nx = ST_DONE;
                    done_nx  = 1'b1;
                    pass_nx  = 1'b1;
                end else begin
                    idx_nx = idx + (AW+1)'(1);
                end
            end
            default: begin
                state_nx     = ST_IDLE;
                cpu_reset_nx = 1'b1;
            end
        endcase

        busy_nx = !((state_nx == ST_IDLE) || (state_nx == ST_DONE));
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state     <= ST_IDLE;
            idx       <= '0;
            len_q     <= '0;
            cnt       <= '0;
            cpu_load  <= 1'b0;
            cpu_instr <= 32'h0;
            cpu_reset <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            fail_idx  <= '0;
        end else begin
            state     <= state_nx;
            idx       <= idx_nx;
            len_q     <= len_nx;
            cnt       <= cnt_nx;
            cpu_load  <= cpu_load_nx;
            cpu_instr <= cpu_instr_nx;
            cpu_reset <= cpu_reset_nx;
            busy      <= busy_nx;
            done      <= done_nx;
            pass      <= pass_nx;
            fail      <= fail_nx;
            fail_idx  <= fail_idx_nx;
        end
    end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 16: program/expect buffer entries.
REQ-002 SHALL have parameter FILL, default 4: cycles from CPU reset release to first result sample.
REQ-003 SHALL have parameter AW, default 4: address width, log2(DEPTH).
REQ-004 SHALL have port clk  in  1: single clock; all state changes on rising edge.
REQ-005 SHALL have port Reset  in  1: reset, asynchronous and active-high.
REQ-006 SHALL have port wr_en  in  1: host buffer write strobe.
REQ-007 SHALL have port wr_sel  in  1: write target; 0 = program word, 1 = expected word.
REQ-008 SHALL have port wr_addr  in  AW: host write index.
REQ-009 SHALL have port wr_data  in  32: host write data.
REQ-010 SHALL have port wr_chk  in  1: check-enable bit, stored with expected word when wr_sel=1.
REQ-011 SHALL have port start  in  1: one-cycle pulse that begins a run.
REQ-012 SHALL have port len  in  AW+1: number of instructions, sampled on start.
REQ-013 SHALL have port cpu_out  in  32: CPU result bus.
REQ-014 SHALL have port cpu_load  out  1: drives CPU LoadInstructions.
REQ-015 SHALL have port cpu_instr  out  32: drives CPU Instruction.
REQ-016 SHALL have port cpu_reset  out  1: drives CPU Reset.
REQ-017 SHALL have port busy  out  1: high in any state other than IDLE and DONE.
REQ-018 SHALL have port done, pass, fail  out  1 each: run status.
REQ-019 SHALL have port fail_idx  out  AW: index of first mismatching result.

Function
REQ-020 SHALL implement FSM IDLE, LOAD, CRST, WAIT, RUN, DONE; all outputs registered.
REQ-021 IDLE/DONE: start=1 latches len, clears done/pass/fail/fail_idx, sets index i=0, enters LOAD next cycle; len=0 goes instead to DONE with pass=1.
REQ-022 LOAD: each cycle cpu_load=1, cpu_reset=0, cpu_instr=prog[i], i increments; after index len-1 go to CRST.
REQ-023 CRST: exactly one cycle with cpu_load=0, cpu_reset=1, cpu_instr=0; then WAIT.
REQ-024 WAIT: cpu_reset=0 for FILL cycles, then RUN with j=0.
REQ-025 RUN: each cycle sample cpu_out at index j; if chk[j]=1 and cpu_out !== exp[j], set fail=1, fail_idx=j, go to DONE immediately.
REQ-026 RUN: chk[j]=0 entries are skipped (no compare, j still advances).
REQ-027 RUN completing index len-1 without mismatch SHALL set pass=1 and go to DONE.
REQ-028 done SHALL be high in DONE only; pass and fail never high together.
REQ-029 start while busy SHALL be ignored; wr_en while busy SHALL be ignored (buffers stable during a run).
REQ-030 len > DEPTH SHALL be saturated to DEPTH at latch time.
REQ-031 Index counters SHALL be AW+1 bits so len=DEPTH terminates without wrap-around aliasing.

Reset
REQ-032 Reset assertion, including mid-run, SHALL force state IDLE, cpu_reset=1, cpu_load=0, cpu_instr=0, busy/done/pass/fail=0, fail_idx=0 immediately (asynchronous).
REQ-033 Buffers (prog, exp, chk) SHALL NOT be reset; contents survive Reset.
REQ-034 cpu_reset SHALL stay 1 in IDLE until the first CRST pulse completes, holding the CPU in reset.

Structure
REQ-035 A shared package SHALL hold the FSM state encodings and the default DEPTH/FILL/AW constants.
REQ-036 Program, expected and check storage SHALL live in one sub-module, loader_buf (dual arrays, one host write port, one read port per array).

Verification
REQ-037 Load 11-word program (addi R1=423 ... add R8), len=11, start -> cpu_load high 11 cycles, instructions in order, then one cpu_reset cycle.
REQ-038 Same program, expected 423,92,13,146,5,569,1,4,3,x,95 with chk[9]=0, correct CPU -> pass=1, done=1, fail=0.
REQ-039 Expected[5]=570 against correct CPU -> fail=1, fail_idx=5, done asserts during the cycle following the sample at j=5.
REQ-040 len=0 start -> done=1, pass=1 next cycle, cpu_load never asserted.
REQ-041 Reset asserted during LOAD at i=3 -> outputs at reset values immediately; new start with len=11 replays full program from index 0.
REQ-042 start and wr_en pulsed during RUN -> no effect; run result identical to an undisturbed run.
